// File: rtl/draw_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// draw_pkg : screen geometry, requester indices and arbiter state encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int N_REQ = 3;

  localparam logic [1:0] REQ_ERASE = 2'd0;
  localparam logic [1:0] REQ_BIRD  = 2'd1;
  localparam logic [1:0] REQ_PIPE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Circular successor over the three requesters (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= REQ_PIPE) ? REQ_ERASE : idx + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = REQ_ERASE;
    if (oh[1]) idx = REQ_BIRD;
    if (oh[2]) idx = REQ_PIPE;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_draw_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_draw_arbiter_if : requester burst buses plus the shared VGA plot port
// Rev 1.0
// ----------------------------------------------------------------------------
interface vga_draw_arbiter_if;
  import draw_pkg::*;

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     plot_in;
  logic [N_REQ-1:0]     last_in;
  logic [N_REQ*X_W-1:0] x_in;
  logic [N_REQ*Y_W-1:0] y_in;
  logic [N_REQ*C_W-1:0] c_in;
  logic [N_REQ-1:0]     gnt;
  logic [X_W-1:0]       vga_x;
  logic [Y_W-1:0]       vga_y;
  logic [C_W-1:0]       vga_colour;
  logic                 vga_plot;

  modport master (
    output req, plot_in, last_in, x_in, y_in, c_in,
    input  gnt, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, plot_in, last_in, x_in, y_in, c_in,
    output gnt, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick3 : first eligible requester at or after ptr, searched circularly
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick3
  import draw_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic       valid
);

  always_comb begin
    logic [1:0] idx;
    grant = 3'b000;
    valid = 1'b0;
    idx   = (ptr > REQ_PIPE) ? REQ_ERASE : ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_draw_arbiter : once-per-frame round-robin sharing of the VGA plot port
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_draw_arbiter
  import draw_pkg::*;
#(
  parameter logic [15:0] MAX_BURST = 16'd20000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  vga_draw_arbiter_if.slave  bus,
  output logic               busy,
  output logic               overrun
);

  arb_state_t state, state_n;

  logic [2:0]     gnt_q, gnt_n;
  logic [2:0]     served, served_n;
  logic [1:0]     ptr, ptr_n;
  logic           tick_pend, tick_pend_n;
  logic [15:0]    cnt, cnt_n;
  logic           overrun_n;
  logic           plot_q, plot_n;
  logic [X_W-1:0] x_q, x_n;
  logic [Y_W-1:0] y_q, y_n;
  logic [C_W-1:0] c_q, c_n;

  logic [1:0]     g_idx;
  logic           g_req, g_plot, g_last;
  logic [X_W-1:0] g_x;
  logic [Y_W-1:0] g_y;
  logic [C_W-1:0] g_c;

  logic           tick_now;
  logic [2:0]     served_eff;
  logic [1:0]     ptr_eff;
  logic [2:0]     eligible;
  logic [2:0]     pick_gnt;
  logic           pick_valid;
  logic           done, abort, wd_hit;

  assign g_idx  = onehot_to_idx(gnt_q);
  assign g_req  = bus.req[g_idx];
  assign g_plot = bus.plot_in[g_idx];
  assign g_last = bus.last_in[g_idx];

  always_comb begin
    g_x = bus.x_in[0 +: X_W];
    g_y = bus.y_in[0 +: Y_W];
    g_c = bus.c_in[0 +: C_W];
    case (g_idx)
      REQ_BIRD: begin
        g_x = bus.x_in[X_W +: X_W];
        g_y = bus.y_in[Y_W +: Y_W];
        g_c = bus.c_in[C_W +: C_W];
      end
      REQ_PIPE: begin
        g_x = bus.x_in[2*X_W +: X_W];
        g_y = bus.y_in[2*Y_W +: Y_W];
        g_c = bus.c_in[2*C_W +: C_W];
      end
      default: ;
    endcase
  end

  // A pending or same-cycle frame tick takes effect before this cycle's pick.
  assign tick_now   = tick_pend | frame_tick;
  assign served_eff = tick_now ? 3'b000 : served;
  assign ptr_eff    = tick_now ? REQ_ERASE : ptr;
  assign eligible   = bus.req & ~served_eff;

  rr_pick3 u_pick (
    .eligible (eligible),
    .ptr      (ptr_eff),
    .grant    (pick_gnt),
    .valid    (pick_valid)
  );

  assign done   = g_plot & g_last;
  assign abort  = ~g_req;
  assign wd_hit = (cnt == MAX_BURST - 16'd1);

  always_comb begin
    state_n     = state;
    gnt_n       = gnt_q;
    served_n    = served;
    ptr_n       = ptr;
    tick_pend_n = tick_pend | frame_tick;
    cnt_n       = cnt;
    overrun_n   = overrun;
    plot_n      = 1'b0;
    x_n         = x_q;
    y_n         = y_q;
    c_n         = c_q;
    case (state)
      ST_IDLE: begin
        served_n    = served_eff;
        ptr_n       = ptr_eff;
        tick_pend_n = 1'b0;
        if (pick_valid) begin
          gnt_n   = pick_gnt;
          cnt_n   = 16'd0;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_n = cnt + 16'd1;
        // An aborting requester's pixel in the same cycle is dropped.
        if (g_plot && g_req) begin
          plot_n = 1'b1;
          x_n    = g_x;
          y_n    = g_y;
          c_n    = g_c;
        end
        if (done || abort || wd_hit) begin
          if (wd_hit && !(done || abort)) overrun_n = 1'b1;
          served_n = served | gnt_q;
          ptr_n    = next_idx(g_idx);
          gnt_n    = 3'b000;
          state_n  = ST_RELEASE;
        end
      end
      ST_RELEASE: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      gnt_q     <= 3'b000;
      served    <= 3'b000;
      ptr       <= REQ_ERASE;
      tick_pend <= 1'b0;
      cnt       <= 16'd0;
      overrun   <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
    end else begin
      state     <= state_n;
      gnt_q     <= gnt_n;
      served    <= served_n;
      ptr       <= ptr_n;
      tick_pend <= tick_pend_n;
      cnt       <= cnt_n;
      overrun   <= overrun_n;
      plot_q    <= plot_n;
      x_q       <= x_n;
      y_q       <= y_n;
      c_q       <= c_n;
    end
  end

  assign busy           = (state != ST_IDLE);
  assign bus.gnt        = gnt_q;
  assign bus.vga_plot   = plot_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = c_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_draw_arbiter : vector table, directed corner sequences, random vs model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vga_draw_arbiter;
  import draw_pkg::*;

  localparam int          MAXB_I = 8;
  localparam logic [15:0] MAX_B  = 16'(MAXB_I);

  logic clk = 1'b0;
  logic resetn;
  logic frame_tick;
  logic busy;
  logic overrun;

  vga_draw_arbiter_if bus();

  vga_draw_arbiter #(.MAX_BURST(MAX_B)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .bus        (bus),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, how long, and what each requester used.
  int             m_owner;
  int             m_len;
  bit             m_gap;
  bit             m_tick;
  bit             m_over;
  bit [2:0]       m_served;
  int             m_ptr;
  bit [2:0]       e_gnt;
  bit             e_plot;
  bit             e_busy;
  logic [X_W-1:0] e_x;
  logic [Y_W-1:0] e_y;
  logic [C_W-1:0] e_c;

  typedef struct {
    bit       ft;
    bit [2:0] req;
    bit [2:0] plot;
    bit [2:0] last;
    int       x;
    bit [2:0] egnt;
    bit       eplot;
    int       ex;
    bit       ebusy;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    bit fin, ab;
    e_plot = 1'b0;
    if (!resetn) begin
      m_owner = -1; m_len = 0; m_gap = 0; m_tick = 0; m_over = 0;
      m_served = 3'b000; m_ptr = 0; e_x = '0; e_y = '0; e_c = '0;
    end else if (m_owner >= 0) begin
      g = m_owner;
      m_len++;
      if (frame_tick) m_tick = 1;
      if (bus.req[g] && bus.plot_in[g]) begin
        e_plot = 1'b1;
        e_x = X_W'(bus.x_in >> (g * X_W));
        e_y = Y_W'(bus.y_in >> (g * Y_W));
        e_c = C_W'(bus.c_in >> (g * C_W));
      end
      fin = bus.plot_in[g] && bus.last_in[g];
      ab  = !bus.req[g];
      if (fin || ab || m_len == MAXB_I) begin
        if (!fin && !ab) m_over = 1;
        m_served[g] = 1'b1;
        m_ptr   = (g + 1) % 3;
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (frame_tick) m_tick = 1;
    end else begin
      if (m_tick || frame_tick) begin
        m_served = 3'b000; m_ptr = 0; m_tick = 0;
      end
      for (int off = 0; off < 3; off++) begin
        int i;
        i = (m_ptr + off) % 3;
        if (m_owner < 0 && bus.req[i] && !m_served[i]) begin
          m_owner = i;
          m_len   = 0;
        end
      end
    end
    e_gnt  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    e_busy = (m_owner >= 0) || m_gap;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("model_gnt", bus.gnt, e_gnt);
    check("model_plot", bus.vga_plot, e_plot);
    check("model_busy", busy, e_busy);
    check("model_overrun", overrun, m_over);
    if (e_plot) begin
      check("model_x", bus.vga_x, e_x);
      check("model_y", bus.vga_y, e_y);
      check("model_colour", bus.vga_colour, e_c);
    end
  endtask

  task automatic set_lane(input int i, input bit p, input bit l, input logic [7:0] x);
    bus.plot_in[i] = p;
    bus.last_in[i] = l;
    bus.x_in[i*X_W +: X_W] = x;
  endtask

  task automatic wait_grant(input int idx, output int waited);
    waited = 0;
    while (bus.gnt == 3'b000 && waited < 12) begin
      cycle();
      waited++;
    end
    check("grant_idx", bus.gnt, 1 << idx);
  endtask

  task automatic stream(input int idx, input int n, input int base);
    for (int p = 0; p < n; p++) begin
      set_lane(idx, 1'b1, (p == n - 1), 8'(base + p));
      cycle();
      check("stream_plot", bus.vga_plot, 1);
      check("stream_x", bus.vga_x, base + p);
    end
    set_lane(idx, 1'b0, 1'b0, 8'd0);
    check("gnt_after_last", bus.gnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, held;

    tbl[0] = '{1'b1, 3'b000, 3'b000, 3'b000,  0, 3'b000, 1'b0,  0, 1'b0};
    tbl[1] = '{1'b0, 3'b010, 3'b000, 3'b000,  0, 3'b010, 1'b0,  0, 1'b1};
    tbl[2] = '{1'b0, 3'b010, 3'b111, 3'b101, 10, 3'b010, 1'b1, 10, 1'b1};
    tbl[3] = '{1'b0, 3'b010, 3'b010, 3'b000, 11, 3'b010, 1'b1, 11, 1'b1};
    tbl[4] = '{1'b0, 3'b010, 3'b010, 3'b000, 12, 3'b010, 1'b1, 12, 1'b1};
    tbl[5] = '{1'b0, 3'b010, 3'b010, 3'b000, 13, 3'b010, 1'b1, 13, 1'b1};
    tbl[6] = '{1'b0, 3'b010, 3'b010, 3'b010, 14, 3'b000, 1'b1, 14, 1'b1};
    tbl[7] = '{1'b0, 3'b010, 3'b000, 3'b000,  0, 3'b000, 1'b0,  0, 1'b0};
    tbl[8] = '{1'b0, 3'b010, 3'b000, 3'b000,  0, 3'b000, 1'b0,  0, 1'b0};

    resetn     = 1'b0;
    frame_tick = 1'b0;
    bus.req     = 3'b000;
    bus.plot_in = 3'b000;
    bus.last_in = 3'b000;
    bus.x_in    = '0;
    bus.y_in    = {7'd70, 7'd50, 7'd30};
    bus.c_in    = {3'd5, 3'd6, 3'd2};

    cycle();
    cycle();
    check("rst_gnt", bus.gnt, 0);
    check("rst_plot", bus.vga_plot, 0);
    check("rst_x", bus.vga_x, 0);
    check("rst_y", bus.vga_y, 0);
    check("rst_colour", bus.vga_colour, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    resetn = 1'b1;

    // Single bird burst: x=10..14, y=50, colour=6, last on the fifth pixel.
    for (int r = 0; r < 9; r++) begin
      frame_tick  = tbl[r].ft;
      bus.req     = tbl[r].req;
      bus.plot_in = tbl[r].plot;
      bus.last_in = tbl[r].last;
      bus.x_in    = {8'hEE, 8'(tbl[r].x), 8'hAA};
      cycle();
      check("tbl_gnt", bus.gnt, tbl[r].egnt);
      check("tbl_plot", bus.vga_plot, tbl[r].eplot);
      check("tbl_busy", busy, tbl[r].ebusy);
      if (tbl[r].eplot) begin
        check("tbl_x", bus.vga_x, tbl[r].ex);
        check("tbl_y", bus.vga_y, 50);
        check("tbl_colour", bus.vga_colour, 6);
      end
    end
    frame_tick  = 1'b0;
    bus.plot_in = 3'b000;
    bus.last_in = 3'b000;
    bus.x_in    = '0;

    // Contention: all three request, order 0,1,2 with a two-sample gap.
    bus.req    = 3'b111;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    wait_grant(0, w);
    check("first_grant_wait", w, 0);
    stream(0, 2, 20);
    wait_grant(1, w);
    check("gap_0_to_1", w, 2);
    stream(1, 2, 30);
    wait_grant(2, w);
    check("gap_1_to_2", w, 2);
    stream(2, 2, 60);
    bus.req = 3'b110;
    cycle();
    bus.req = 3'b111;
    repeat (4) cycle();
    check("no_regrant_same_frame", bus.gnt, 0);

    // Tick mid-burst: bird burst completes, then requester 0 wins again.
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    wait_grant(0, w);
    stream(0, 2, 80);
    wait_grant(1, w);
    frame_tick = 1'b1;
    set_lane(1, 1'b1, 1'b0, 8'd40);
    cycle();
    frame_tick = 1'b0;
    check("tick_keeps_grant", bus.gnt, 3'b010);
    stream(1, 2, 41);
    wait_grant(0, w);
    check("tick_regrant_wait", w, 2);
    stream(0, 2, 90);

    // Abort: pipe drops req mid-burst.
    wait_grant(1, w);
    stream(1, 1, 50);
    wait_grant(2, w);
    set_lane(2, 1'b1, 1'b0, 8'd77);
    cycle();
    check("abort_pre_plot", bus.vga_plot, 1);
    check("abort_pre_x", bus.vga_x, 77);
    bus.req = 3'b011;
    set_lane(2, 1'b1, 1'b0, 8'd99);
    cycle();
    check("abort_no_plot", bus.vga_plot, 0);
    check("abort_gnt", bus.gnt, 0);
    check("abort_overrun", overrun, 0);
    set_lane(2, 1'b0, 1'b0, 8'd0);
    bus.req = 3'b100;
    repeat (4) cycle();
    check("abort_served", bus.gnt, 0);

    // Watchdog: bird never marks last.
    bus.req    = 3'b010;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    check("wd_grant", bus.gnt, 3'b010);
    held = 1;
    set_lane(1, 1'b1, 1'b0, 8'd5);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (bus.gnt == 3'b010) held++;
      else break;
    end
    check("wd_grant_cycles", held, MAXB_I);
    check("wd_overrun", overrun, 1);
    set_lane(1, 1'b0, 1'b0, 8'd0);
    bus.req = 3'b000;
    repeat (2) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      repeat (3) cycle();
    end
    check("wd_overrun_sticky", overrun, 1);

    // Reset during a grant.
    bus.req    = 3'b001;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    check("rstmid_grant", bus.gnt, 3'b001);
    set_lane(0, 1'b1, 1'b0, 8'd33);
    cycle();
    check("rstmid_plot_before", bus.vga_plot, 1);
    resetn = 1'b0;
    cycle();
    check("rstmid_gnt", bus.gnt, 0);
    check("rstmid_plot", bus.vga_plot, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_overrun", overrun, 0);
    check("rstmid_x", bus.vga_x, 0);
    resetn = 1'b1;
    set_lane(0, 1'b0, 1'b0, 8'd0);
    bus.req = 3'b000;
    cycle();

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      resetn     = ($urandom_range(0, 499) != 0);
      frame_tick = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
        bus.plot_in[i] = ($urandom_range(0, 1) == 1);
        bus.last_in[i] = ($urandom_range(0, 5) == 0);
      end
      bus.x_in = 24'($urandom);
      bus.y_in = 21'($urandom);
      bus.c_in = 9'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_draw_arbiter.md
# vga_draw_arbiter

Sequences and shares the single VGA adapter plot port between the game's pixel-drawing requesters: background/erase (requester 0), bird sprite (requester 1) and pipe sprites (requester 2). Each requester asks for a burst, receives an exclusive grant, streams pixels and marks the last one. The arbiter muxes the winner's pixel onto the VGA port with one registered stage, serves each requester at most once per frame, and guards against runaway bursts with a watchdog. It sits between the bird/pipe control datapaths and `vga_adapter`.

## Interface
- X_W, 8, x coordinate width (160-wide screen)
- Y_W, 7, y coordinate width (120-tall screen)
- C_W, 3, colour width
- MAX_BURST, 16'd20000, maximum cycles a grant may be held
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of each game frame
- req  in  3  burst request per requester, level
- plot_in  in  3  per-requester pixel-valid strobe
- last_in  in  3  per-requester final-pixel marker, qualified by plot_in
- x_in  in  3*X_W  packed x buses, requester i at [i*X_W +: X_W]
- y_in  in  3*Y_W  packed y buses
- c_in  in  3*C_W  packed colour buses
- gnt  out  3  one-hot grant, at most one bit set
- vga_x  out  X_W  to adapter
- vga_y  out  Y_W  to adapter
- vga_colour  out  C_W  to adapter
- vga_plot  out  1  to adapter write enable
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  sticky; set on watchdog release, cleared only by reset

## Operation
- States: IDLE, GRANT, RELEASE.
- Eligible set: `req & ~served`. `served` (3 bits) is cleared on applied frame tick.
- IDLE: if the eligible set is non-zero, pick the first eligible index at or after `ptr`, searching circularly (0→1→2→0). Set `gnt` one-hot, clear the watchdog counter, go to GRANT.
- GRANT: the granted requester's plot_in/x/y/c pass to the VGA outputs. Exit to RELEASE on any of the following:
  - (a) `plot_in[g] & last_in[g]`: normal completion.
  - (b) `req[g]` low: abort; the pixel on that cycle is not forwarded.
  - (c) the counter reaches MAX_BURST−1: set `overrun`.
- On every exit: set `served[g]`, set `ptr = g+1` mod 3, and clear `gnt` on entry to RELEASE.
- RELEASE: one-cycle dead gap with no grant and no plot. Then go to IDLE.
- frame_tick: latched into `tick_pend` in any state. It is applied only in IDLE: clear `served`, set `ptr=0`, clear `tick_pend`.
  - The apply happens in the same cycle as arbitration. The cleared `served` is used for that cycle's decision.
  - A tick arriving mid-burst never alters the current grant.
- Non-granted requesters' plot_in values are ignored.

## Timing
- Reset values:
  - Outputs: `gnt=0`, `vga_plot=0`, `vga_x/y/colour=0`, `busy=0`, `overrun=0`.
  - Internal: `served=0`, `ptr=0`, `tick_pend=0`, state IDLE.
- Request latency: req seen in IDLE at cycle n gives `gnt` at n+1.
- Pixel latency: a pixel on `x_in/plot_in` at cycle k (with gnt high) appears on `vga_*` at k+1.
- Last pixel: `last_in` at cycle k is plotted at k+1. `gnt` drops at k+1. The earliest next grant is at k+3.
- Watchdog: the counter increments each GRANT cycle. Forced release happens on the MAX_BURST-th cycle of the grant.
- Mid-operation reset returns everything to reset values on the next edge.

## Structure
- Shared package `draw_pkg`:
  - Requester index constants: REQ_ERASE=0, REQ_BIRD=1, REQ_PIPE=2.
  - State encodings.
  - Screen width constants X_W/Y_W/C_W, shared with the bird and pipe datapaths.
- Sub-module `rr_pick3`: combinational circular first-eligible picker. Inputs are eligible[2:0] and ptr[1:0]. Outputs are one-hot grant and a valid flag.
- Everything else lives in the top module.

## Test plan
- Single request: reset, pulse frame_tick, req=3'b010. Bird streams 5 pixels (x=10..14, y=50, c=3'b110) with last on the 5th.
  - gnt=010 one cycle after req.
  - vga_plot high for exactly 5 cycles, lagging one cycle, with matching coordinates.
  - gnt=000 after the last pixel; busy low two cycles later.
- Contention: frame_tick, then req=3'b111 with 2-pixel bursts each.
  - Grant order is 0, 1, 2, with one RELEASE gap between grants.
  - A re-asserted req[0] is not granted again until the next frame_tick.
- Tick mid-burst: frame_tick while requester 1 is granted.
  - The burst completes uninterrupted.
  - After RELEASE, served is cleared and ptr=0, so requester 0 (still requesting) is granted next.
- Abort: requester 2 drops req mid-burst.
  - The pixel in that cycle is not plotted.
  - gnt clears and served[2]=1.
  - overrun stays 0.
- Watchdog: run with MAX_BURST=8. Requester 1 holds req and never asserts last.
  - Forced release on the 8th grant cycle.
  - overrun=1 and stays 1 through later frames until resetn=0.
- Reset mid-burst: assert resetn=0 during a grant.
  - On the next edge, gnt=0, vga_plot=0, busy=0, overrun=0.
